regfile_multiport: RTL and testbench
====================================

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, range 1..4, meaning number of independent read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 always reads 0 and ignores writes.
REQ-005 SHALL have parameter READ_REG, default 0; 0 gives combinational reads, 1 gives registered reads.
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port rd_addr  input  NUM_RD*ADDR_W  read addresses; port k is bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rd_data  output  NUM_RD*DATA_W  read data; port k is bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port wr_en  input  2  write enables; bit 0 for write port A, bit 1 for write port B.
REQ-011 SHALL have port wr_addr_a  input  ADDR_W  write port A address.
REQ-012 SHALL have port wr_data_a  input  DATA_W  write port A data.
REQ-013 SHALL have port wr_addr_b  input  ADDR_W  write port B address.
REQ-014 SHALL have port wr_data_b  input  DATA_W  write port B data.
REQ-015 SHALL have port wr_conflict  output  1  registered flag: the previous cycle had both enables set with equal addresses.

Function
REQ-016 SHALL update storage only on the rising clk edge; writes are never level-sensitive.
REQ-017 SHALL write wr_data_a to entry wr_addr_a when wr_en[0]=1, and wr_data_b to entry wr_addr_b when wr_en[1]=1, in the same cycle.
REQ-018 SHALL store port B's data when both ports write the same address in one cycle; port B has priority.
REQ-019 SHALL set wr_conflict=1 on the edge after a same-address dual write and clear it on the edge after any other cycle.
REQ-020 SHALL assert wr_conflict for a same-address dual write to entry 0 when ZERO_REG=1, even though no data is stored.
REQ-021 SHALL discard any write to entry 0 when ZERO_REG=1; entry 0 stays 0.
REQ-022 SHALL make every read of entry 0 return 0 when ZERO_REG=1, including bypassed reads.
REQ-023 SHALL, when READ_REG=0, drive rd_data[k] combinationally from entry rd_addr[k], with write-through bypass: a same-cycle enabled write to that address is returned instead of the stored value, with port B taking priority over port A.
REQ-024 SHALL, when READ_REG=1, register rd_data[k] on each edge with the post-write value of entry rd_addr[k] sampled that cycle, so a same-cycle write is visible: 1-cycle latency, bypass included.
REQ-025 SHALL handle each read port independently; any number of ports may read the same address.
REQ-026 SHALL leave storage unchanged in a cycle with wr_en=2'b00.

Reset
REQ-027 SHALL clear all storage entries to 0 on any rising edge with rst=1.
REQ-028 SHALL clear wr_conflict, and the registered rd_data when READ_REG=1, to 0 on that edge.
REQ-029 SHALL ignore wr_en during a reset cycle, so reset beats a concurrent write.
REQ-030 SHALL, when READ_REG=0, make rd_data reflect the cleared contents from the cycle after reset; bypass stays active while rst=1.
REQ-031 SHALL, when rst falls mid-sequence, accept writes from the first cycle with rst=0.

Verification
REQ-032 Dual write: write A to addr 3 with 0x11111111 and B to addr 7 with 0x22222222, then read port 0 at 3 and port 1 at 7 -> 0x11111111 and 0x22222222; wr_conflict=0.
REQ-033 Collision: in one cycle A writes 0xAAAA0000 and B writes 0xBBBB0000, both to addr 9 -> addr 9 reads 0xBBBB0000; wr_conflict=1 for exactly one cycle.
REQ-034 Zero register (ZERO_REG=1): write 0xDEADBEEF to addr 0 while reading addr 0 -> reads 0 in that cycle and after; with ZERO_REG=0, reads 0xDEADBEEF.
REQ-035 Bypass (READ_REG=0): read addr 5 while A writes 0x12345678 to addr 5 -> rd_data shows 0x12345678 in the same cycle. With READ_REG=1 -> 0x12345678 on the following cycle.
REQ-036 Reset: fill all 32 entries with their index, assert rst for 1 cycle while wr_en=2'b11 -> every entry reads 0 and wr_conflict=0.
REQ-037 Parameter sweep: DATA_W=8, ADDR_W=3, NUM_RD=4; random writes checked against a reference model -> all four ports match every cycle.

Source files
------------

// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
//
// Purpose:
//   Register file with a parameterised number of read ports and two write
//   ports (A and B).
//   - Write port B has priority when both ports write the same address.
//   - Entry 0 can be made a hardwired zero (ZERO_REG).
//   - Reads are either combinational with write-through bypass, or registered
//     with one cycle of latency (READ_REG).
//   - A registered flag reports same-address dual writes.
//
// Ports:
//   clk          input   1              single clock, rising edge
//   rst          input   1              synchronous active-high reset
//   rd_addr      input   NUM_RD*ADDR_W  read addresses, port k = [k*ADDR_W +: ADDR_W]
//   rd_data      output  NUM_RD*DATA_W  read data, port k = [k*DATA_W +: DATA_W]
//   wr_en        input   2              bit 0 = write port A, bit 1 = write port B
//   wr_addr_a    input   ADDR_W         write port A address
//   wr_data_a    input   DATA_W         write port A data
//   wr_addr_b    input   ADDR_W         write port B address
//   wr_data_b    input   DATA_W         write port B data
//   wr_conflict  output  1              previous cycle was a same-address dual write
// ---------------------------------------------------------------------------
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int READ_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [1:0]               wr_en,
  input  logic [ADDR_W-1:0]        wr_addr_a,
  input  logic [DATA_W-1:0]        wr_data_a,
  input  logic [ADDR_W-1:0]        wr_addr_b,
  input  logic [DATA_W-1:0]        wr_data_b,
  output logic                     wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic                     wr_ok_a;
  logic                     wr_ok_b;
  logic [NUM_RD*DATA_W-1:0] rd_next;

  // A write only "counts" when it is enabled and does not target the
  // hardwired zero entry. Both the storage update and the read bypass use
  // these qualified enables, so a discarded write can never leak out.
  assign wr_ok_a = wr_en[0] && !((ZERO_REG != 0) && (wr_addr_a == '0));
  assign wr_ok_b = wr_en[1] && !((ZERO_REG != 0) && (wr_addr_b == '0));

  // Storage and conflict flag.
  // Port B is written after port A, so on an address collision B's
  // non-blocking assignment wins.
  // The conflict flag looks at the raw enables, not the qualified ones, so a
  // dual write to entry 0 is still reported even though nothing is stored.
  // Reset takes precedence over any concurrent write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_conflict <= 1'b0;
    end else begin
      if (wr_ok_a) begin
        mem[wr_addr_a] <= wr_data_a;
      end
      if (wr_ok_b) begin
        mem[wr_addr_b] <= wr_data_b;
      end
      wr_conflict <= (wr_en == 2'b11) && (wr_addr_a == wr_addr_b);
    end
  end

  // Post-write view of each read port.
  // Start from the stored value, then let a same-cycle write replace it
  // (B after A, so B has priority), and finally force entry 0 to zero.
  // This value feeds the output directly, or through a register, depending
  // on READ_REG. The bypass deliberately ignores rst.
  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_next[k*DATA_W +: DATA_W] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
      if (wr_ok_a && (wr_addr_a == rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_next[k*DATA_W +: DATA_W] = wr_data_a;
      end
      if (wr_ok_b && (wr_addr_b == rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_next[k*DATA_W +: DATA_W] = wr_data_b;
      end
      if ((ZERO_REG != 0) && (rd_addr[k*ADDR_W +: ADDR_W] == '0)) begin
        rd_next[k*DATA_W +: DATA_W] = '0;
      end
    end
  end

  // Output stage.
  // In registered mode, rd_next is captured every edge, so a write in the
  // same cycle shows up one cycle later. In combinational mode, rd_next is
  // passed straight through.
  if (READ_REG != 0) begin : g_rd_reg
    logic [NUM_RD*DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_next;
      end
    end

    assign rd_data = rd_q;
  end else begin : g_rd_comb
    assign rd_data = rd_next;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// ---------------------------------------------------------------------------
// tb_regfile_multiport
//
// Purpose:
//   Directed self-checking bench for regfile_multiport. It instantiates three
//   copies of the design:
//     dut_c : default parameters (zero register, combinational reads).
//     dut_r : ZERO_REG=0, READ_REG=1. Shares every input with dut_c.
//     dut_s : DATA_W=8, ADDR_W=3, NUM_RD=4. Checked against a small
//             reference model under random writes.
// ---------------------------------------------------------------------------
module tb_regfile_multiport;

  logic        clk;
  logic        rst;

  // Shared stimulus for the two 32-bit instances.
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [4:0]  wr_addr_a;
  logic [31:0] wr_data_a;
  logic [4:0]  wr_addr_b;
  logic [31:0] wr_data_b;
  logic [63:0] rd_data_c;
  logic [63:0] rd_data_r;
  logic        conflict_c;
  logic        conflict_r;

  // Stimulus for the small parameter-sweep instance.
  logic [11:0] rd_addr_s;
  logic [31:0] rd_data_s;
  logic [1:0]  wr_en_s;
  logic [2:0]  wr_addr_a_s;
  logic [7:0]  wr_data_a_s;
  logic [2:0]  wr_addr_b_s;
  logic [7:0]  wr_data_b_s;
  logic        conflict_s;

  // Reference state for the sweep instance.
  logic [7:0]  model [8];
  logic        exp_conf_s;

  int n_checks = 0;
  int n_fails  = 0;

  regfile_multiport dut_c (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data_c),
    .wr_en       (wr_en),
    .wr_addr_a   (wr_addr_a),
    .wr_data_a   (wr_data_a),
    .wr_addr_b   (wr_addr_b),
    .wr_data_b   (wr_data_b),
    .wr_conflict (conflict_c)
  );

  regfile_multiport #(.ZERO_REG(0), .READ_REG(1)) dut_r (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data_r),
    .wr_en       (wr_en),
    .wr_addr_a   (wr_addr_a),
    .wr_data_a   (wr_data_a),
    .wr_addr_b   (wr_addr_b),
    .wr_data_b   (wr_data_b),
    .wr_conflict (conflict_r)
  );

  regfile_multiport #(.DATA_W(8), .ADDR_W(3), .NUM_RD(4)) dut_s (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr_s),
    .rd_data     (rd_data_s),
    .wr_en       (wr_en_s),
    .wr_addr_a   (wr_addr_a_s),
    .wr_data_a   (wr_data_a_s),
    .wr_addr_b   (wr_addr_b_s),
    .wr_data_b   (wr_data_b_s),
    .wr_conflict (conflict_s)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and reports any
  // difference.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drives one cycle's worth of inputs onto the shared 32-bit interface.
  task automatic applyStimulus(input logic [1:0] en,
                               input logic [4:0] aa, input logic [31:0] da,
                               input logic [4:0] ab, input logic [31:0] db,
                               input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en     = en;
    wr_addr_a = aa;
    wr_data_a = da;
    wr_addr_b = ab;
    wr_data_b = db;
    rd_addr   = {ra1, ra0};
    #1;
  endtask

  // Advances one clock edge and leaves time 1 unit past it, away from the
  // edge, before any sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected read value for the sweep instance.
  // Starts from the stored contents, applies the same-cycle bypass with
  // port B winning, and forces entry 0 to read as zero.
  function automatic logic [7:0] modelRead(input logic [2:0] ra);
    logic [7:0] v;
    v = model[ra];
    if (wr_en_s[0] && wr_addr_a_s == ra) v = wr_data_a_s;
    if (wr_en_s[1] && wr_addr_b_s == ra) v = wr_data_b_s;
    if (ra == 3'd0) v = 8'h00;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    rd_addr_s = '0; wr_en_s = '0; wr_addr_a_s = '0; wr_data_a_s = '0;
    wr_addr_b_s = '0; wr_data_b_s = '0;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    exp_conf_s = 1'b0;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();
    step();
    rst = 1'b0;

    // Reset state.
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd7);
    checkOutput("reset_rd_c",       rd_data_c, 64'h0);
    checkOutput("reset_rd_r",       rd_data_r, 64'h0);
    checkOutput("reset_conflict_c", {63'h0, conflict_c}, 64'h0);
    checkOutput("reset_conflict_r", {63'h0, conflict_r}, 64'h0);

    // Dual write to different addresses.
    applyStimulus(2'b11, 5'd3, 32'h11111111, 5'd7, 32'h22222222, 5'd3, 5'd7);
    checkOutput("dual_bypass_c", rd_data_c, 64'h22222222_11111111);
    step();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd7);
    checkOutput("dual_rd_c",       rd_data_c, 64'h22222222_11111111);
    checkOutput("dual_rd_r",       rd_data_r, 64'h22222222_11111111);
    checkOutput("dual_conflict_c", {63'h0, conflict_c}, 64'h0);

    // Same-address collision: port B must win.
    applyStimulus(2'b11, 5'd9, 32'hAAAA0000, 5'd9, 32'hBBBB0000, 5'd9, 5'd9);
    checkOutput("coll_bypass_c", rd_data_c, 64'hBBBB0000_BBBB0000);
    step();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9);
    checkOutput("coll_rd_c",       rd_data_c, 64'hBBBB0000_BBBB0000);
    checkOutput("coll_rd_r",       rd_data_r, 64'hBBBB0000_BBBB0000);
    checkOutput("coll_conflict_c", {63'h0, conflict_c}, 64'h1);
    checkOutput("coll_conflict_r", {63'h0, conflict_r}, 64'h1);
    step();
    checkOutput("coll_clear_c", {63'h0, conflict_c}, 64'h0);

    // Writes to entry 0: hardwired zero in dut_c, stored in dut_r.
    applyStimulus(2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("zero_bypass_c", rd_data_c[31:0], 64'h0);
    step();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("zero_rd_c", rd_data_c[31:0], 64'h0);
    checkOutput("zero_rd_r", rd_data_r[31:0], 64'hDEADBEEF);
    step();
    checkOutput("zero_hold_r", rd_data_r[31:0], 64'hDEADBEEF);

    // Dual write to entry 0: conflict is still flagged.
    applyStimulus(2'b11, 5'd0, 32'h1, 5'd0, 32'h2, 5'd0, 5'd0);
    step();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
    checkOutput("zero_conflict_c", {63'h0, conflict_c}, 64'h1);
    checkOutput("zero_dual_rd_c",  rd_data_c[31:0], 64'h0);
    checkOutput("zero_dual_rd_r",  rd_data_r[31:0], 64'h2);

    // Bypass timing: same cycle when combinational, next cycle when
    // registered.
    applyStimulus(2'b01, 5'd5, 32'h12345678, 5'd0, 32'h0, 5'd5, 5'd5);
    checkOutput("byp_same_c", rd_data_c, 64'h12345678_12345678);
    checkOutput("byp_old_r",  rd_data_r[31:0], 64'h2);
    step();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd5);
    checkOutput("byp_next_r", rd_data_r, 64'h12345678_12345678);

    // Fill every entry with its index, then reset during a colliding write.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(2'b01, 5'(i), 32'(i), 5'd0, 32'h0, 5'd0, 5'd0);
      step();
    end
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd17, 5'd0);
    checkOutput("fill_rd_c", rd_data_c, {32'd0, 32'd17});
    step();
    checkOutput("fill_rd_r", rd_data_r, {32'd0, 32'd17});

    rst = 1'b1;
    applyStimulus(2'b11, 5'd4, 32'h0000FFFF, 5'd4, 32'h0000EEEE, 5'd4, 5'd6);
    checkOutput("rst_bypass_c", rd_data_c[31:0], 64'h0000EEEE);
    step();
    rst = 1'b0;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd6);
    checkOutput("rst_conflict_c", {63'h0, conflict_c}, 64'h0);
    checkOutput("rst_conflict_r", {63'h0, conflict_r}, 64'h0);
    checkOutput("rst_rd_r",       rd_data_r, 64'h0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      checkOutput($sformatf("rst_clear_c_%0d", i), rd_data_c, 64'h0);
      step();
      checkOutput($sformatf("rst_clear_r_%0d", i), rd_data_r, 64'h0);
    end

    // Parameter sweep instance: random writes checked against the model.
    // Entry 0 is skipped when updating the model, as it always reads zero.
    for (int cyc = 0; cyc < 60; cyc++) begin
      wr_en_s     = 2'($urandom_range(0, 3));
      wr_addr_a_s = 3'($urandom_range(0, 7));
      wr_data_a_s = 8'($urandom_range(0, 255));
      wr_addr_b_s = 3'($urandom_range(0, 7));
      wr_data_b_s = 8'($urandom_range(0, 255));
      rd_addr_s   = 12'($urandom);
      #1;
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("sweep_c%0d_p%0d", cyc, k),
                    64'(rd_data_s[k*8 +: 8]),
                    64'(modelRead(rd_addr_s[k*3 +: 3])));
      end
      exp_conf_s = (wr_en_s == 2'b11) && (wr_addr_a_s == wr_addr_b_s);
      @(posedge clk);
      if (wr_en_s[0] && wr_addr_a_s != 3'd0) model[wr_addr_a_s] = wr_data_a_s;
      if (wr_en_s[1] && wr_addr_b_s != 3'd0) model[wr_addr_b_s] = wr_data_b_s;
      #1;
      checkOutput($sformatf("sweep_conflict_%0d", cyc),
                  {63'h0, conflict_s}, {63'h0, exp_conf_s});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
